reg_check_monitor: RTL and testbench

- Parametrised, self-checking end-of-program checker that sits beside any CPU core variant (single-cycle, multi-cycle, pipeline) on its debug outputs.
- Holds a loadable table of expected register values.
- After start, detects program completion (PC parked at a halt address and stable for a drain window) or a timeout.
- Then compares table entries against the register-file snapshot, one entry per cycle, and reports pass/fail.
- Replaces fixed per-core wait-cycle counts with completion detection.

---
 rtl/reg_check_monitor_pkg.sv | 27 ++
 rtl/reg_check_monitor_if.sv | 48 ++++
 rtl/reg_check_monitor_check_table.sv | 44 ++++
 rtl/reg_check_monitor.sv | 195 +++++++++++++++++++
 tb/tb_reg_check_monitor.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_check_monitor_pkg.sv
// Shared types for the end-of-program register checker: FSM state,
// expected-value table entry and the per-entry compare helper.
package reg_check_pkg;

    localparam int NUM_ARCH_REGS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    // 'reg' is a keyword, so the register-number field is reg_idx.
    typedef struct packed {
        logic        valid;
        logic [4:0]  reg_idx;
        logic [31:0] val;
        logic [31:0] mask;
    } chk_entry_t;

    // An entry fails only when it is valid and a masked bit differs.
    function automatic logic entry_mismatch(input chk_entry_t e, input logic [31:0] actual);
        return e.valid && (((actual ^ e.val) & e.mask) != 32'h0000_0000);
    endfunction

endpackage

// File: rtl/reg_check_monitor_if.sv
// Bus between a test harness (master) and reg_check_monitor (slave):
// run control, core debug taps, table load port and result status.
// fail_bitmap exists only when REG_CHECK_TRACE_EN is defined.
interface reg_check_monitor_if #(
    parameter int NUM_CHECKS = 32
);
    localparam int AW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int CW = $clog2(NUM_CHECKS + 1);

    logic                  start;
    logic [31:0]           pc_debug;
    logic [31:0][31:0]     regs_debug;
    logic                  exp_we;
    logic [AW-1:0]         exp_addr;
    logic [4:0]            exp_reg;
    logic [31:0]           exp_val;
    logic [31:0]           exp_mask;
    logic                  exp_clear;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic                  timed_out;
    logic [CW-1:0]         fail_count;
    logic [AW-1:0]         first_fail_idx;
    logic [31:0]           cycle_count;
`ifdef REG_CHECK_TRACE_EN
    logic [NUM_CHECKS-1:0] fail_bitmap;
`endif

    modport master (
        output start, pc_debug, regs_debug,
        output exp_we, exp_addr, exp_reg, exp_val, exp_mask, exp_clear,
        input  busy, done, pass, timed_out, fail_count, first_fail_idx, cycle_count
`ifdef REG_CHECK_TRACE_EN
        , input fail_bitmap
`endif
    );

    modport slave (
        input  start, pc_debug, regs_debug,
        input  exp_we, exp_addr, exp_reg, exp_val, exp_mask, exp_clear,
        output busy, done, pass, timed_out, fail_count, first_fail_idx, cycle_count
`ifdef REG_CHECK_TRACE_EN
        , output fail_bitmap
`endif
    );

endinterface

// File: rtl/reg_check_monitor_check_table.sv
// Expected-value table: gated write/clear port and combinational read.
// A write in the same cycle as a clear leaves the written entry valid.
module check_table
    import reg_check_pkg::*;
#(
    parameter int NUM_CHECKS = 32,
    parameter int AW         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          accept,
    input  logic          we,
    input  logic          clear,
    input  logic [AW-1:0] wr_addr,
    input  logic [4:0]    wr_reg,
    input  logic [31:0]   wr_val,
    input  logic [31:0]   wr_mask,
    input  logic [AW-1:0] rd_idx,
    output chk_entry_t    rd_entry
);

    chk_entry_t table_r [NUM_CHECKS];

    // Entry storage: clear first, then the write so a same-cycle write wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                table_r[i] <= '0;
            end
        end else if (accept) begin
            if (clear) begin
                for (int i = 0; i < NUM_CHECKS; i++) begin
                    table_r[i].valid <= 1'b0;
                end
            end
            if (we) begin
                table_r[wr_addr] <= '{valid: 1'b1, reg_idx: wr_reg, val: wr_val, mask: wr_mask};
            end
        end
    end

    assign rd_entry = table_r[rd_idx];

endmodule

// File: rtl/reg_check_monitor.sv
// End-of-program register checker. Waits for the core PC to park at
// END_PC for SETTLE_CYCLES consecutive cycles (or times out), then walks
// the expected-value table one entry per cycle against the live register
// file and reports pass/fail. Optional macro REG_CHECK_TRACE_EN adds
// per-entry trace prints and the fail_bitmap output.
module reg_check_monitor
    import reg_check_pkg::*;
#(
    parameter int          NUM_CHECKS     = 32,
    parameter logic [31:0] END_PC         = 32'h0000_0058,
    parameter int          SETTLE_CYCLES  = 8,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input logic             clk,
    input logic             reset,
    reg_check_monitor_if.slave bus
);

    localparam int AW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int CW = $clog2(NUM_CHECKS + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [SW-1:0] SETTLE_LIM  = SW'(SETTLE_CYCLES);
    localparam logic [31:0]   TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
    localparam logic [AW-1:0] LAST_IDX    = AW'(NUM_CHECKS - 1);
    localparam logic [CW-1:0] FAIL_SAT    = CW'(NUM_CHECKS);

    chk_state_t    state_r;
    logic [AW-1:0] idx_r;
    logic [SW-1:0] settle_r;
    logic [31:0]   cycle_count_r;
    logic [CW-1:0] fail_count_r;
    logic [AW-1:0] first_fail_r;
    logic          busy_r;
    logic          done_r;
    logic          pass_r;
    logic          timed_out_r;
`ifdef REG_CHECK_TRACE_EN
    logic [NUM_CHECKS-1:0] fail_bitmap_r;
`endif

    logic          table_accept_s;
    logic          start_accept_s;
    logic [SW-1:0] settle_next_s;
    logic [31:0]   cycle_next_s;
    chk_entry_t    entry_s;
    logic [31:0]   actual_s;
    logic          entry_fail_s;
    logic [CW-1:0] fail_count_next_s;

    check_table #(
        .NUM_CHECKS (NUM_CHECKS),
        .AW         (AW)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .accept   (table_accept_s),
        .we       (bus.exp_we),
        .clear    (bus.exp_clear),
        .wr_addr  (bus.exp_addr),
        .wr_reg   (bus.exp_reg),
        .wr_val   (bus.exp_val),
        .wr_mask  (bus.exp_mask),
        .rd_idx   (idx_r),
        .rd_entry (entry_s)
    );

    // Next-value helpers: table/start gating, settle and cycle counters, entry compare.
    always_comb begin
        table_accept_s    = (state_r == IDLE) || (state_r == DONE);
        start_accept_s    = bus.start && table_accept_s;
        settle_next_s     = '0;
        cycle_next_s      = cycle_count_r + 32'd1;
        actual_s          = bus.regs_debug[entry_s.reg_idx];
        entry_fail_s      = entry_mismatch(entry_s, actual_s);
        fail_count_next_s = fail_count_r;
        if (bus.pc_debug == END_PC) begin
            settle_next_s = settle_r + SW'(1);
        end else begin
            settle_next_s = '0;
        end
        if (entry_fail_s && (fail_count_r != FAIL_SAT)) begin
            fail_count_next_s = fail_count_r + CW'(1);
        end else begin
            fail_count_next_s = fail_count_r;
        end
    end

    // Run-control FSM with counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            idx_r         <= '0;
            settle_r      <= '0;
            cycle_count_r <= 32'h0000_0000;
            fail_count_r  <= '0;
            first_fail_r  <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timed_out_r   <= 1'b0;
`ifdef REG_CHECK_TRACE_EN
            fail_bitmap_r <= '0;
`endif
        end else if (start_accept_s) begin
            state_r       <= RUN;
            idx_r         <= '0;
            settle_r      <= '0;
            cycle_count_r <= 32'h0000_0000;
            fail_count_r  <= '0;
            first_fail_r  <= '0;
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timed_out_r   <= 1'b0;
`ifdef REG_CHECK_TRACE_EN
            fail_bitmap_r <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                RUN: begin
                    cycle_count_r <= cycle_next_s;
                    settle_r      <= settle_next_s;
                    // Settle completion takes priority over a coincident timeout.
                    if (settle_next_s == SETTLE_LIM) begin
                        state_r      <= CHECK;
                        idx_r        <= '0;
                        fail_count_r <= '0;
                        first_fail_r <= '0;
                    end else if (cycle_next_s == TIMEOUT_LIM) begin
                        state_r     <= DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        timed_out_r <= 1'b1;
                        pass_r      <= 1'b0;
`ifdef REG_CHECK_TRACE_EN
                        $display("reg_check_monitor: timed out after %0d cycles", cycle_next_s);
`endif
                    end
                end
                CHECK: begin
                    fail_count_r <= fail_count_next_s;
                    if (entry_fail_s && (fail_count_r == '0)) begin
                        first_fail_r <= idx_r;
                    end
`ifdef REG_CHECK_TRACE_EN
                    fail_bitmap_r[idx_r] <= entry_fail_s;
                    if (entry_s.valid) begin
                        $display("reg_check_monitor: idx %0d x%0d exp 0x%08h act 0x%08h %s",
                                 idx_r, entry_s.reg_idx, entry_s.val, actual_s,
                                 entry_fail_s ? "FAIL" : "PASS");
                    end
`endif
                    if (idx_r == LAST_IDX) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= (fail_count_next_s == '0) && !timed_out_r;
`ifdef REG_CHECK_TRACE_EN
                        $display("reg_check_monitor: done, %0d failing entries, cycles %0d",
                                 fail_count_next_s, cycle_count_r);
`endif
                    end else begin
                        idx_r <= idx_r + AW'(1);
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    pass_r      <= 1'b0;
                    timed_out_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.pass           = pass_r;
    assign bus.timed_out      = timed_out_r;
    assign bus.fail_count     = fail_count_r;
    assign bus.first_fail_idx = first_fail_r;
    assign bus.cycle_count    = cycle_count_r;
`ifdef REG_CHECK_TRACE_EN
    assign bus.fail_bitmap    = fail_bitmap_r;
`endif

endmodule

// File: tb/tb_reg_check_monitor.sv
// Directed bench for reg_check_monitor: a table of whole-run scenarios
// (table contents, register file, PC arrival) with hand-computed results,
// followed by hand-written multi-cycle sequences for reset, ignored
// writes/start, result hold and re-run.
module tb_reg_check_monitor;

    localparam logic [31:0] END_PC = 32'h0000_0058;
    localparam int NEVER = 100000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reg_check_monitor_if #(.NUM_CHECKS(32)) bus();

    reg_check_monitor #(
        .NUM_CHECKS     (32),
        .END_PC         (END_PC),
        .SETTLE_CYCLES  (8),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_applied = 0;
    int n_miscompare = 0;

    typedef struct {
        int   arrive;
        bit   glitch;
        int   tbl;
        int   rv;
        logic e_pass;
        logic e_to;
        int   e_fc;
        int   e_ffi;
        int   e_cc;
        int   e_lat;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_entry(input int idx, input int r, input logic [31:0] v, input logic [31:0] m);
        bus.exp_we   = 1'b1;
        bus.exp_addr = 5'(idx);
        bus.exp_reg  = 5'(r);
        bus.exp_val  = v;
        bus.exp_mask = m;
        tick();
        bus.exp_we   = 1'b0;
    endtask

    task automatic load_table(input int t);
        case (t)
            0: begin
                write_entry(0, 8,  32'h0000_000A, 32'hFFFF_FFFF);
                write_entry(1, 9,  32'h0000_0014, 32'hFFFF_FFFF);
                write_entry(2, 10, 32'h0000_001E, 32'hFFFF_FFFF);
                write_entry(3, 12, 32'hFFFF_FFF6, 32'hFFFF_FFFF);
                write_entry(4, 17, 32'h0000_0050, 32'hFFFF_FFFF);
            end
            1: write_entry(0, 5, 32'h0000_00FF, 32'h0000_00FF);
            2: write_entry(31, 5, 32'h0000_00FF, 32'hFFFF_FFFF);
            3: begin end
            4: begin
                write_entry(3,  10, 32'h0000_001E, 32'hFFFF_FFFF);
                write_entry(7,  0,  32'h0000_0000, 32'hFFFF_FFFF);
                write_entry(20, 9,  32'h0000_0099, 32'hFFFF_FFFF);
            end
            default: begin
                for (int i = 0; i < 32; i++) begin
                    write_entry(i, 1, 32'h0000_DEAD, 32'hFFFF_FFFF);
                end
            end
        endcase
    endtask

    task automatic set_regs(input int rv);
        for (int r = 0; r < 32; r++) begin
            bus.regs_debug[r] = 32'h1000_0000 + 32'(r);
        end
        bus.regs_debug[0]  = 32'h0000_0001;
        bus.regs_debug[1]  = 32'h0000_0000;
        bus.regs_debug[5]  = 32'hFFFF_FFFF;
        bus.regs_debug[8]  = 32'h0000_000A;
        bus.regs_debug[9]  = 32'h0000_0014;
        bus.regs_debug[10] = 32'h0000_001E;
        bus.regs_debug[12] = (rv == 1) ? 32'hFFFF_FFF5 : 32'hFFFF_FFF6;
        bus.regs_debug[17] = (rv == 1) ? 32'h0000_0040 : 32'h0000_0050;
    endtask

    function automatic logic [31:0] pc_at(input int k, input int a, input bit g);
        if (g && k >= 10 && k < 15) return END_PC;
        else if (g && k >= 15 && k < a) return 32'h0000_0020;
        else if (k >= a) return END_PC;
        else return 32'h0000_0100 + 32'(k * 4);
    endfunction

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Drives the PC profile after start and returns the cycle done was first seen.
    task automatic run_loop(input int a, input bit g, input bit meddle, output int lat);
        lat = -1;
        for (int k = 0; k < 1200; k++) begin
            bus.pc_debug = pc_at(k, a, g);
            if (meddle) begin
                if (k == 2) begin
                    bus.start    = 1'b1;
                    bus.exp_we   = 1'b1;
                    bus.exp_addr = 5'd10;
                    bus.exp_reg  = 5'd12;
                    bus.exp_val  = 32'h0000_1234;
                    bus.exp_mask = 32'hFFFF_FFFF;
                end else if (k == 3) begin
                    bus.start     = 1'b0;
                    bus.exp_we    = 1'b0;
                    bus.exp_clear = 1'b1;
                end else begin
                    bus.exp_clear = 1'b0;
                end
            end
            tick();
            if (bus.done === 1'b1) begin
                lat = k + 1;
                break;
            end
        end
        bus.start     = 1'b0;
        bus.exp_we    = 1'b0;
        bus.exp_clear = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic e_pass, input logic e_to,
                                input int e_fc, input int e_ffi, input int e_cc,
                                input int e_lat, input int lat);
        chk({tag, "_latency"},   32'(lat),                32'(e_lat));
        chk({tag, "_done"},      32'(bus.done),           32'd1);
        chk({tag, "_busy"},      32'(bus.busy),           32'd0);
        chk({tag, "_pass"},      32'(bus.pass),           32'(e_pass));
        chk({tag, "_timed_out"}, 32'(bus.timed_out),      32'(e_to));
        chk({tag, "_fail_cnt"},  32'(bus.fail_count),     32'(e_fc));
        chk({tag, "_first_idx"}, 32'(bus.first_fail_idx), 32'(e_ffi));
        chk({tag, "_cycles"},    bus.cycle_count,         32'(e_cc));
    endtask

    initial begin
        int lat;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.pc_debug  = 32'h0000_0000;
        bus.exp_we    = 1'b0;
        bus.exp_addr  = 5'd0;
        bus.exp_reg   = 5'd0;
        bus.exp_val   = 32'h0000_0000;
        bus.exp_mask  = 32'h0000_0000;
        bus.exp_clear = 1'b0;
        set_regs(0);

        //          arrive glitch tbl rv pass to fc ffi  cc    lat
        vecs[0]  = '{40,    1'b0, 0, 0, 1'b1, 1'b0, 0,  0,  48,   80};
        vecs[1]  = '{40,    1'b0, 0, 1, 1'b0, 1'b0, 2,  3,  48,   80};
        vecs[2]  = '{NEVER, 1'b0, 0, 0, 1'b0, 1'b1, 0,  0,  1024, 1024};
        vecs[3]  = '{20,    1'b1, 0, 0, 1'b1, 1'b0, 0,  0,  28,   60};
        vecs[4]  = '{3,     1'b0, 1, 0, 1'b1, 1'b0, 0,  0,  11,   43};
        vecs[5]  = '{3,     1'b0, 2, 0, 1'b0, 1'b0, 1,  31, 11,   43};
        vecs[6]  = '{0,     1'b0, 3, 0, 1'b1, 1'b0, 0,  0,  8,    40};
        vecs[7]  = '{0,     1'b0, 4, 0, 1'b0, 1'b0, 2,  7,  8,    40};
        vecs[8]  = '{5,     1'b0, 5, 0, 1'b0, 1'b0, 32, 0,  13,   45};
        vecs[9]  = '{1016,  1'b0, 0, 0, 1'b1, 1'b0, 0,  0,  1024, 1056};
        vecs[10] = '{1017,  1'b0, 0, 0, 1'b0, 1'b1, 0,  0,  1024, 1024};

        // Reset state
        do_reset();
        chk("rst_busy",      32'(bus.busy),           32'd0);
        chk("rst_done",      32'(bus.done),           32'd0);
        chk("rst_pass",      32'(bus.pass),           32'd0);
        chk("rst_timed_out", 32'(bus.timed_out),      32'd0);
        chk("rst_fail_cnt",  32'(bus.fail_count),     32'd0);
        chk("rst_first_idx", 32'(bus.first_fail_idx), 32'd0);
        chk("rst_cycles",    bus.cycle_count,         32'd0);

        // Scenario table
        for (int i = 0; i < 11; i++) begin
            do_reset();
            set_regs(vecs[i].rv);
            load_table(vecs[i].tbl);
            do_start();
            chk($sformatf("v%0d_busy_run", i), 32'(bus.busy), 32'd1);
            run_loop(vecs[i].arrive, vecs[i].glitch, 1'b0, lat);
            check_result($sformatf("v%0d", i), vecs[i].e_pass, vecs[i].e_to, vecs[i].e_fc,
                         vecs[i].e_ffi, vecs[i].e_cc, vecs[i].e_lat, lat);
        end

        // Reset in the middle of CHECK aborts and invalidates the table
        do_reset();
        set_regs(1);
        load_table(0);
        do_start();
        for (int k = 0; k < 18; k++) begin
            bus.pc_debug = END_PC;
            tick();
        end
        chk("midchk_busy",     32'(bus.busy),       32'd1);
        chk("midchk_fail_cnt", 32'(bus.fail_count), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy",     32'(bus.busy),       32'd0);
        chk("abort_done",     32'(bus.done),       32'd0);
        chk("abort_fail_cnt", 32'(bus.fail_count), 32'd0);
        do_start();
        run_loop(0, 1'b0, 1'b0, lat);
        check_result("after_abort", 1'b1, 1'b0, 0, 0, 8, 40, lat);

        // Start, write and clear during RUN are ignored
        do_reset();
        set_regs(1);
        load_table(0);
        do_start();
        run_loop(10, 1'b0, 1'b1, lat);
        check_result("meddle", 1'b0, 1'b0, 2, 3, 18, 50, lat);

        // Results hold in DONE
        tick();
        tick();
        tick();
        chk("hold_done",     32'(bus.done),       32'd1);
        chk("hold_fail_cnt", 32'(bus.fail_count), 32'd2);

        // Second start from DONE clears status and keeps the table
        do_start();
        chk("rerun_done",     32'(bus.done),        32'd0);
        chk("rerun_busy",     32'(bus.busy),        32'd1);
        chk("rerun_fail_cnt", 32'(bus.fail_count),  32'd0);
        chk("rerun_cycles",   bus.cycle_count,      32'd0);
        run_loop(0, 1'b0, 1'b0, lat);
        check_result("rerun", 1'b0, 1'b0, 2, 3, 8, 40, lat);

        // Clear and write in the same DONE cycle: written entry survives
        bus.exp_clear = 1'b1;
        write_entry(0, 12, 32'hFFFF_FFF6, 32'hFFFF_FFFF);
        bus.exp_clear = 1'b0;
        do_start();
        run_loop(0, 1'b0, 1'b0, lat);
        check_result("clr_wr", 1'b0, 1'b0, 1, 0, 8, 40, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
